// File: rtl/row_cache_pkg.sv
// -----------------------------------------------------------------------------
// row_cache_pkg
// Shared definitions for the per-bank row-cache tag controller:
//   - BankFSM state codes that trigger a cache lookup (WRITING / READING)
//   - controller FSM state enum (IDLE / MISS / ACTIVE)
//   - slot entry struct {valid, dirty, tag}
// The slot tag field is sized to TAG_MAX_W so the struct can live in a
// non-parameterised package; rows narrower than that are zero-extended.
// -----------------------------------------------------------------------------
package row_cache_pkg;

    localparam logic [4:0] WRITING   = 5'b10010;
    localparam logic [4:0] READING   = 5'b01011;
    localparam int         TAG_MAX_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MISS   = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    typedef struct packed {
        logic                 valid;
        logic                 dirty;
        logic [TAG_MAX_W-1:0] tag;
    } slot_t;

    function automatic logic is_access(input logic [4:0] code);
        return (code == WRITING) || (code == READING);
    endfunction

endpackage

// File: rtl/row_cache_ctrl_if.sv
// -----------------------------------------------------------------------------
// row_cache_ctrl_if
// Access / miss-request bundle between the bank datapath and the row cache.
//   inputs to cache : bg, ba, RowId, BankFSM, sync
//   outputs of cache: cRowId, hit, hold, miss_valid, miss_wb, miss_wb_row,
//                     miss_fill_row, miss_bg, miss_ba
//   with CACHE_STATS_EN defined: hit_count, miss_count, wb_count
// Modports: slave = cache controller, master = bank datapath.
// -----------------------------------------------------------------------------
interface row_cache_ctrl_if #(
    parameter int BGWIDTH   = 2,
    parameter int BAWIDTH   = 2,
    parameter int CHWIDTH   = 5,
    parameter int ADDRWIDTH = 17,
    parameter int STATWIDTH = 32
);
    logic [BGWIDTH-1:0]   bg;
    logic [BAWIDTH-1:0]   ba;
    logic [ADDRWIDTH-1:0] RowId;
    logic [4:0]           BankFSM;
    logic                 sync;
    logic [CHWIDTH-1:0]   cRowId;
    logic                 hit;
    logic                 hold;
    logic                 miss_valid;
    logic                 miss_wb;
    logic [ADDRWIDTH-1:0] miss_wb_row;
    logic [ADDRWIDTH-1:0] miss_fill_row;
    logic [BGWIDTH-1:0]   miss_bg;
    logic [BAWIDTH-1:0]   miss_ba;
`ifdef CACHE_STATS_EN
    logic [STATWIDTH-1:0] hit_count;
    logic [STATWIDTH-1:0] miss_count;
    logic [STATWIDTH-1:0] wb_count;
`else
    logic [STATWIDTH-1:0] unused_stat_w;
    assign unused_stat_w = '0;
`endif

    modport slave (
        input  bg, ba, RowId, BankFSM, sync,
        output cRowId, hit, hold, miss_valid, miss_wb, miss_wb_row,
               miss_fill_row, miss_bg, miss_ba
`ifdef CACHE_STATS_EN
        , output hit_count, miss_count, wb_count
`endif
    );

    modport master (
        output bg, ba, RowId, BankFSM, sync,
        input  cRowId, hit, hold, miss_valid, miss_wb, miss_wb_row,
               miss_fill_row, miss_bg, miss_ba
`ifdef CACHE_STATS_EN
        , input hit_count, miss_count, wb_count
`endif
    );
endinterface

// File: rtl/row_cache_lookup.sv
// -----------------------------------------------------------------------------
// row_cache_lookup
// Combinational tag compare and victim selection for the slots of one bank.
//   i_slots     : slot entries of the addressed bank
//   i_row       : row being looked up
//   i_ptr       : round-robin victim pointer of that bank
//   o_hit       : a valid slot holds i_row
//   o_hit_idx   : index of that slot
//   o_vic_idx   : lowest invalid slot, else i_ptr
//   o_vic_entry : contents of the victim slot
// -----------------------------------------------------------------------------
module row_cache_lookup
    import row_cache_pkg::*;
#(
    parameter int CHWIDTH   = 5,
    parameter int ADDRWIDTH = 17
) (
    input  slot_t                i_slots [2**CHWIDTH],
    input  logic [ADDRWIDTH-1:0] i_row,
    input  logic [CHWIDTH-1:0]   i_ptr,
    output logic                 o_hit,
    output logic [CHWIDTH-1:0]   o_hit_idx,
    output logic [CHWIDTH-1:0]   o_vic_idx,
    output slot_t                o_vic_entry
);
    localparam int CHROWS = 2**CHWIDTH;

    logic               w_has_free;
    logic [CHWIDTH-1:0] w_free_idx;

    // Scanning from the top down lets the lowest matching / free index win.
    always_comb begin
        o_hit      = 1'b0;
        o_hit_idx  = '0;
        w_has_free = 1'b0;
        w_free_idx = '0;
        for (int i = CHROWS - 1; i >= 0; i--) begin
            if (i_slots[i].valid && (i_slots[i].tag == TAG_MAX_W'(i_row))) begin
                o_hit     = 1'b1;
                o_hit_idx = CHWIDTH'(i);
            end
            if (!i_slots[i].valid) begin
                w_has_free = 1'b1;
                w_free_idx = CHWIDTH'(i);
            end
        end
    end

    assign o_vic_idx   = w_has_free ? w_free_idx : i_ptr;
    assign o_vic_entry = i_slots[o_vic_idx];

endmodule

// File: rtl/row_cache_ctrl.sv
// -----------------------------------------------------------------------------
// row_cache_ctrl
// Per-bank row-cache tag controller. Maps (bg, ba, RowId) of a READING or
// WRITING bank to a cache slot cRowId, tracks valid/dirty per slot, and on a
// miss holds the bank while a fill (optionally preceded by a writeback of a
// dirty victim) is outstanding until sync.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : access inputs, slot/hit result, miss request outputs
// Optional macro CACHE_STATS_EN adds saturating hit/miss/writeback counters.
// -----------------------------------------------------------------------------
module row_cache_ctrl
    import row_cache_pkg::*;
#(
    parameter int BGWIDTH   = 2,
    parameter int BAWIDTH   = 2,
    parameter int CHWIDTH   = 5,
    parameter int ADDRWIDTH = 17,
    parameter int STATWIDTH = 32
) (
    input logic             clk,
    input logic             reset_n,
    row_cache_ctrl_if.slave bus
);
    localparam int CHROWS = 2**CHWIDTH;
    localparam int BKW    = BGWIDTH + BAWIDTH;
    localparam int NBANK  = 2**BKW;

    state_t r_state, w_next;

    logic [CHROWS-1:0]    r_valid [NBANK];
    logic [CHROWS-1:0]    r_dirty [NBANK];
    logic [ADDRWIDTH-1:0] r_tag   [NBANK][CHROWS];
    logic [CHWIDTH-1:0]   r_ptr   [NBANK];

    logic [BKW-1:0]       r_mbank;
    logic [CHWIDTH-1:0]   r_mslot;
    logic [ADDRWIDTH-1:0] r_mrow;
    logic                 r_mwr;
    logic                 r_wb;
    logic [ADDRWIDTH-1:0] r_wb_row;
    logic                 r_from_ptr;
    logic [CHWIDTH-1:0]   r_crow;
    logic                 r_hit;

    logic [BKW-1:0]     w_bank;
    logic               w_access;
    logic               w_write;
    logic               w_lookup_go;
    logic               w_fill_done;
    slot_t              w_slots [CHROWS];
    logic               w_hit;
    logic [CHWIDTH-1:0] w_hit_idx;
    logic [CHWIDTH-1:0] w_vic_idx;
    slot_t              w_vic;
    logic               w_vic_wb;
    logic               w_unused_tag;

    assign w_bank      = {bus.bg, bus.ba};
    assign w_access    = is_access(bus.BankFSM);
    assign w_write     = (bus.BankFSM == WRITING);
    assign w_lookup_go = (r_state == IDLE) && w_access;
    assign w_fill_done = (r_state == MISS) && bus.sync;
    assign w_vic_wb    = w_vic.valid & w_vic.dirty;
    assign w_unused_tag = ^w_vic.tag;

    always_comb begin
        for (int i = 0; i < CHROWS; i++) begin
            w_slots[i].valid = r_valid[w_bank][i];
            w_slots[i].dirty = r_dirty[w_bank][i];
            w_slots[i].tag   = TAG_MAX_W'(r_tag[w_bank][i]);
        end
    end

    row_cache_lookup #(
        .CHWIDTH   (CHWIDTH),
        .ADDRWIDTH (ADDRWIDTH)
    ) u_lookup (
        .i_slots     (w_slots),
        .i_row       (bus.RowId),
        .i_ptr       (r_ptr[w_bank]),
        .o_hit       (w_hit),
        .o_hit_idx   (w_hit_idx),
        .o_vic_idx   (w_vic_idx),
        .o_vic_entry (w_vic)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_access) w_next = w_hit ? ACTIVE : MISS;
            MISS:    if (bus.sync) w_next = ACTIVE;
            ACTIVE:  if (!w_access) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        bus.hold          = (r_state == MISS);
        bus.miss_valid    = (r_state == MISS);
        bus.miss_wb       = (r_state == MISS) && r_wb;
        bus.miss_wb_row   = r_wb_row;
        bus.miss_fill_row = r_mrow;
        bus.miss_bg       = r_mbank[BKW-1:BAWIDTH];
        bus.miss_ba       = r_mbank[BAWIDTH-1:0];
        bus.cRowId        = r_crow;
        bus.hit           = r_hit;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int b = 0; b < NBANK; b++) begin
                r_valid[b] <= '0;
                r_dirty[b] <= '0;
                r_ptr[b]   <= '0;
            end
            r_mbank    <= '0;
            r_mslot    <= '0;
            r_mrow     <= '0;
            r_mwr      <= 1'b0;
            r_wb       <= 1'b0;
            r_wb_row   <= '0;
            r_from_ptr <= 1'b0;
            r_crow     <= '0;
            r_hit      <= 1'b0;
        end else begin
            if (w_lookup_go) begin
                if (w_hit) begin
                    r_crow <= w_hit_idx;
                    r_hit  <= 1'b1;
                    if (w_write) r_dirty[w_bank][w_hit_idx] <= 1'b1;
                end else begin
                    r_mbank    <= w_bank;
                    r_mslot    <= w_vic_idx;
                    r_mrow     <= bus.RowId;
                    r_mwr      <= w_write;
                    r_wb       <= w_vic_wb;
                    // Invalid slots carry stale (unreset) tags; report 0 instead.
                    r_wb_row   <= w_vic.valid ? w_vic.tag[ADDRWIDTH-1:0] : '0;
                    // A valid victim means no free slot existed, so it came from the pointer.
                    r_from_ptr <= w_vic.valid;
                end
            end
            if (w_fill_done) begin
                r_valid[r_mbank][r_mslot] <= 1'b1;
                r_dirty[r_mbank][r_mslot] <= r_mwr;
                r_crow <= r_mslot;
                r_hit  <= 1'b0;
                if (r_from_ptr) r_ptr[r_mbank] <= r_ptr[r_mbank] + 1'b1;
            end
            if ((r_state == ACTIVE) && !w_access) r_hit <= 1'b0;
        end
    end

    // Tag storage needs no reset: a tag is only ever read when its valid bit is set.
    always_ff @(posedge clk) begin
        if (w_fill_done) r_tag[r_mbank][r_mslot] <= r_mrow;
    end

`ifdef CACHE_STATS_EN
    logic [STATWIDTH-1:0] r_hit_cnt, r_miss_cnt, r_wb_cnt;

    function automatic logic [STATWIDTH-1:0] sat_inc(input logic [STATWIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
            r_wb_cnt   <= '0;
        end else if (w_lookup_go) begin
            if (w_hit) begin
                r_hit_cnt <= sat_inc(r_hit_cnt);
            end else begin
                r_miss_cnt <= sat_inc(r_miss_cnt);
                if (w_vic_wb) r_wb_cnt <= sat_inc(r_wb_cnt);
            end
        end
    end

    assign bus.hit_count  = r_hit_cnt;
    assign bus.miss_count = r_miss_cnt;
    assign bus.wb_count   = r_wb_cnt;
`else
    logic [STATWIDTH-1:0] w_unused_stat;
    assign w_unused_stat = '0;
`endif

endmodule

// File: doc/row_cache_ctrl.md
Name: row_cache_ctrl

Overview:
Parametrised per-bank row-cache tag controller for the DRAM emulation datapath.
- Maps the (bg, ba, RowId) of the addressed bank's read/write to a cache row slot cRowId.
- Tracks valid/dirty per slot and picks victims per bank.
- On a miss, stalls the bank FSM via hold and issues a fill/writeback request, completed by the sync acknowledge.
- Successor to the single-mapping cache FSM: adds dirty tracking, writeback signalling and per-bank victim selection.

Parameters:
BGWIDTH, 2, bank-group address width; BANKGROUPS = 2**BGWIDTH
BAWIDTH, 2, bank address width; BANKSPERGROUP = 2**BAWIDTH
CHWIDTH, 5, cache slot index width; CHROWS = 2**CHWIDTH slots per bank
ADDRWIDTH, 17, DRAM row address width
STATWIDTH, 32, statistics counter width (used only with CACHE_STATS_EN)

Ports:
clk  in  1  clock
reset_n  in  1  reset, asynchronous, active-low
bg  in  BGWIDTH  bank group of current access
ba  in  BAWIDTH  bank of current access
RowId  in  ADDRWIDTH  DRAM row of current access
BankFSM  in  5  state code of addressed bank; 5'b10010 = WRITING, 5'b01011 = READING, others idle
sync  in  1  fill/writeback complete acknowledge
cRowId  out  CHWIDTH  cache slot for current access
hit  out  1  current access hit (valid in ACTIVE)
hold  out  1  stall addressed bank; high in MISS
miss_valid  out  1  fill request outstanding (equals hold)
miss_wb  out  1  victim dirty, writeback required before fill
miss_wb_row  out  ADDRWIDTH  row to write back
miss_fill_row  out  ADDRWIDTH  row to fill
miss_bg / miss_ba  out  BGWIDTH / BAWIDTH  latched bank of the miss
hit_count / miss_count / wb_count  out  STATWIDTH each  present only with CACHE_STATS_EN

Behaviour:
- Storage per bank: CHROWS entries of {valid, dirty, tag[ADDRWIDTH]}, plus a CHWIDTH-bit round-robin victim pointer.
- Reset (async, reset_n=0):
  - all valid/dirty = 0, pointers = 0, FSM = IDLE.
  - outputs cRowId=0, hit=0, hold=0, miss_*=0, counters=0.
  - Reset mid-MISS abandons the request; the outstanding sync is then ignored.
- FSM states: IDLE, MISS, ACTIVE.
- IDLE:
  - If BankFSM is READING or WRITING, compare RowId against all valid tags of bank {bg,ba}. The compare is combinational; its result is registered.
  - Hit: next cycle cRowId = matching index, hit=1, state ACTIVE. WRITING sets that slot's dirty bit; READING leaves dirty unchanged. Latency is 1 cycle.
  - Miss, victim selection: the lowest-index invalid slot; if none, the slot at the victim pointer.
  - Miss, next cycle: state MISS, hold=miss_valid=1, miss_wb = victim valid & dirty, miss_wb_row = victim tag, miss_fill_row = RowId. Bank, slot, RowId and op are latched.
- MISS:
  - hold stays high until sync=1 is sampled.
  - On sync: install tag, valid=1, dirty = (op was WRITING), cRowId = victim, hit=0.
  - Victim pointer advances only if the victim was taken from the pointer, wrapping from CHROWS-1 to 0.
  - Next cycle: hold=miss_valid=miss_wb=0, state ACTIVE.
  - bg/ba/RowId/BankFSM changes during MISS are ignored. The miss always completes because a fill is in flight.
- ACTIVE:
  - cRowId and hit are held.
  - When BankFSM is neither READING nor WRITING, go to IDLE; hit falls to 0 and cRowId holds its value.
  - One lookup per contiguous access burst.
- sync outside MISS is ignored.
- Matching is unique by construction, since a tag is installed only on a miss.

Optional Feature:
- CACHE_STATS_EN defined:
  - hit_count increments on each IDLE hit, miss_count on each MISS entry, wb_count on each MISS entry with miss_wb=1.
  - All three saturate at all-ones and reset to 0.
- Undefined: the counter ports and logic are absent.

Decomposition:
- Package row_cache_pkg holds:
  - BankFSM codes WRITING=5'b10010 and READING=5'b01011.
  - FSM state enum {IDLE, MISS, ACTIVE}.
  - Slot entry struct {valid, dirty, tag}.
- One sub-module, row_cache_lookup: combinational tag compare plus victim selection for one bank. Outputs hit, hit index, victim index and victim entry.

Test Plan:
- Cold read, bank (0,0) RowId=0x1234 READING: 1 cycle later hold=1, miss_wb=0, miss_fill_row=0x1234. Sync pulse -> cRowId=0, then hold=0. Re-read -> hit=1, cRowId=0 after 1 cycle.
- Fill all 32 slots of bank (1,2) with WRITING of distinct rows (32 misses with sync) -> slots 0..31 in order, all dirty.
- Next miss on bank (1,2), RowId=0x1FFFF -> victim slot 0, miss_wb=1, miss_wb_row = first row written. Following miss -> slot 1 (pointer advanced and wraps after 31).
- Same RowId=0x00AA in banks (0,0) and (3,3) -> independent misses, both cRowId=0. Write hit in (3,3) sets only that dirty bit.
- Reset asserted while hold=1 -> outputs zero immediately. A later sync has no effect, and a re-access misses with miss_wb=0.
- CACHE_STATS_EN: 3 misses (1 writeback) and 5 hits -> miss_count=3, wb_count=1, hit_count=5. Sync pulses in IDLE change no state.
